// File: rtl/sipo_word_receiver_if.sv
// Serial-in / word-out bundle between the PISO bit stream, the receiver and the word consumer.
// slave = receiver side; master = the environment that drives bits and accepts words.
interface sipo_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             sdi;
  logic             sdi_en;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overflow;
  logic             clr_ovf;
  logic             busy;

  modport slave (
    input  sdi, sdi_en, sync, dout_ready, clr_ovf,
    output dout, dout_valid, overflow, busy
  );

  modport master (
    output sdi, sdi_en, sync, dout_ready, clr_ovf,
    input  dout, dout_valid, overflow, busy
  );
endinterface

// File: rtl/sipo_word_receiver.sv
// MSB-first serial-to-parallel word receiver with 2-entry output FIFO; word visible 1 cycle after its last bit.
// Valid/ready output; a completed word arriving at a full FIFO with no pop is dropped and sets sticky overflow.
module sipo_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sipo_word_receiver_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             ovf;

  logic             word_done;
  logic [WIDTH-1:0] new_word;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    word_done = bus.sdi_en && !bus.sync && (bit_cnt == LAST);
    new_word  = {shreg[WIDTH-2:0], bus.sdi};
    pop       = (count != 2'd0) && bus.dout_ready;
    push      = word_done && ((count != 2'd2) || pop);
    drop      = word_done && (count == 2'd2) && !pop;
  end

  // A sync bit is itself the first bit of the new word, so it still shifts in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (bus.sdi_en)
        shreg <= {shreg[WIDTH-2:0], bus.sdi};
      if (bus.sync)
        bit_cnt <= bus.sdi_en ? CW'(1) : '0;
      else if (bus.sdi_en)
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++)
        mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over a same-edge clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
    else if (bus.clr_ovf)
      ovf <= 1'b0;
  end

  assign bus.dout       = mem[rd_ptr];
  assign bus.dout_valid = (count != 2'd0);
  assign bus.overflow   = ovf;
  assign bus.busy       = (bit_cnt != '0);
endmodule

// File: tb/tb_sipo_word_receiver.sv
// Randomized + directed bench for sipo_word_receiver against a bit-list / word-queue reference model.
module tb_sipo_word_receiver;
  localparam int W = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  sipo_word_receiver_if #(.WIDTH(W)) bus ();

  sipo_word_receiver #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bits received since the last word boundary, and the queue of buffered words.
  bit           m_bits [$];
  logic [W-1:0] m_fifo [$];
  bit           m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_bits.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      bit           pop, full, got, drop;
      logic [W-1:0] w;
      pop  = (m_fifo.size() != 0) && (bus.dout_ready === 1'b1);
      full = (m_fifo.size() == 2);
      got  = 1'b0;
      drop = 1'b0;
      w    = '0;
      if (bus.sync) begin
        m_bits.delete();
        if (bus.sdi_en) m_bits.push_back(bus.sdi);
      end else if (bus.sdi_en) begin
        m_bits.push_back(bus.sdi);
        if (m_bits.size() == W) begin
          foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
          got = 1'b1;
          m_bits.delete();
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (got) begin
        if (!full || pop) m_fifo.push_back(w);
        else drop = 1'b1;
      end
      if (bus.clr_ovf) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("valid", 16'(bus.dout_valid), 16'(m_fifo.size() != 0));
    chk("busy", 16'(bus.busy), 16'(m_bits.size() != 0));
    chk("overflow", 16'(bus.overflow), 16'(m_ovf));
    if (m_fifo.size() != 0)
      chk("dout", 16'(bus.dout), 16'(m_fifo[0]));
  end

  // Drive one cycle of inputs (called at a falling edge), then wait for the next falling edge.
  task automatic cyc(input bit d, input bit en, input bit sy, input bit rdy, input bit clr);
    bus.sdi        = d;
    bus.sdi_en     = en;
    bus.sync       = sy;
    bus.dout_ready = rdy;
    bus.clr_ovf    = clr;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit sync_first, input bit rdy);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--)
      cyc(v[i], 1'b1, sync_first && (i == W - 1), rdy, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.sdi = 1'b0; bus.sdi_en = 1'b0; bus.sync = 1'b0; bus.dout_ready = 1'b0; bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 16'(bus.dout_valid), 16'h0);
    chk("rst_dout", 16'(bus.dout), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_ovf", 16'(bus.overflow), 16'h0);
    reset_n = 1'b1;

    // PISO preload 0101, sync on first bit, consumer always ready
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_early", 16'(bus.dout_valid), 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 16'(bus.dout_valid), 16'h1);
    chk("t1_dout", 16'(bus.dout), 16'h5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_once", 16'(bus.dout_valid), 16'h0);

    // back-to-back words into a stalled consumer
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0);
    chk("t2_ovf", 16'(bus.overflow), 16'h1);
    chk("t2_head", 16'(bus.dout), 16'hA);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_second", 16'(bus.dout), 16'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_empty", 16'(bus.dout_valid), 16'h0);
    chk("t2_ovf_sticky", 16'(bus.overflow), 16'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", 16'(bus.overflow), 16'h0);

    // full FIFO, third word completes on the same edge as a pop
    send_word(4'h1, 1'b0, 1'b0);
    send_word(4'h2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_no_ovf", 16'(bus.overflow), 16'h0);
    chk("t3_head", 16'(bus.dout), 16'h2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_next", 16'(bus.dout), 16'h7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_empty", 16'(bus.dout_valid), 16'h0);

    // sync realignment discards a 2-bit partial word
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(4'h9, 1'b1, 1'b0);
    chk("t4_valid", 16'(bus.dout_valid), 16'h1);
    chk("t4_dout", 16'(bus.dout), 16'h9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_only_one", 16'(bus.dout_valid), 16'h0);

    // qualifier gaps with junk on sdi
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_busy_first", 16'(bus.busy), 16'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_busy_gap", 16'(bus.busy), 16'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_busy_done", 16'(bus.busy), 16'h0);
    chk("t5_dout", 16'(bus.dout), 16'h6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-word with a word pending
    send_word(4'h5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.sdi_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", 16'(bus.dout_valid), 16'h0);
    chk("t6_dout", 16'(bus.dout), 16'h0);
    chk("t6_busy", 16'(bus.busy), 16'h0);
    chk("t6_ovf", 16'(bus.overflow), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    send_word(4'h9, 1'b0, 1'b0);
    chk("t6_after", 16'(bus.dout), 16'h9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom), $urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
          1'($urandom), $urandom_range(29, 0) == 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
